// File: rtl/time_set_ctrl.sv
// Time-setting editor: shadow HH:MM:SS edited by button pulses, committed to the timekeeper with a load strobe.
// Optional field blinking is built when TIME_SET_BLINK_EN is defined.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 30,
  parameter int unsigned HOUR_MAX  = 23
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_wr_pulse,
  input  logic       i_val_inc_pulse,
  input  logic       i_val_dec_pulse,
  input  logic       i_sel_inc_pulse,
  input  logic       i_sel_dec_pulse,
  input  logic [4:0] i_cur_hh,
  input  logic [5:0] i_cur_mm,
  input  logic [5:0] i_cur_ss,
  output logic       o_edit,
  output logic [1:0] o_sel,
  output logic [4:0] o_disp_hh,
  output logic [5:0] o_disp_mm,
  output logic [5:0] o_disp_ss,
  output logic       o_load,
  output logic [4:0] o_set_hh,
  output logic [5:0] o_set_mm,
  output logic [5:0] o_set_ss,
  output logic [2:0] o_blink_mask
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_S - 1);
  localparam logic [4:0] HH_MAX = 5'(HOUR_MAX);
  localparam logic [5:0] MS_MAX = 6'd59;

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [4:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d, ss_q, ss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edit_q, edit_d, load_q, load_d;
  logic [4:0]       disp_hh_q, disp_hh_d, set_hh_q, set_hh_d;
  logic [5:0]       disp_mm_q, disp_mm_d, disp_ss_q, disp_ss_d;
  logic [5:0]       set_mm_q, set_mm_d, set_ss_q, set_ss_d;

  logic sel_any, val_any, accepted;
  assign sel_any  = i_sel_inc_pulse | i_sel_dec_pulse;
  assign val_any  = i_val_inc_pulse | i_val_dec_pulse;
  assign accepted = i_wr_pulse | sel_any | val_any;

  function automatic logic [5:0] ms_step(input logic [5:0] v, input logic up);
    if (up) ms_step = (v == MS_MAX) ? 6'd0 : v + 6'd1;
    else    ms_step = (v == 6'd0) ? MS_MAX : v - 6'd1;
  endfunction

  function automatic logic [4:0] hh_step(input logic [4:0] v, input logic up);
    if (up) hh_step = (v == HH_MAX) ? 5'd0 : v + 5'd1;
    else    hh_step = (v == 5'd0) ? HH_MAX : v - 5'd1;
  endfunction

  // State and shadow registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      hh_q    <= 5'd0;
      mm_q    <= 6'd0;
      ss_q    <= 6'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, field selection, shadow edits and inactivity timeout
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_wr_pulse) begin
          state_d = S_EDIT;
          hh_d    = i_cur_hh;
          mm_d    = i_cur_mm;
          ss_d    = i_cur_ss;
          sel_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      S_EDIT: begin
        if (accepted) begin
          cnt_d = '0;
        end else if (i_tick) begin
          if (cnt_q == TO_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (i_wr_pulse) begin
          state_d = S_COMMIT;
        end else if (sel_any) begin
          if (i_sel_inc_pulse && !i_sel_dec_pulse)
            sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
          else if (i_sel_dec_pulse && !i_sel_inc_pulse)
            sel_d = (sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1;
        end else if (i_val_inc_pulse ^ i_val_dec_pulse) begin
          unique case (sel_q)
            2'd0:    hh_d = hh_step(hh_q, i_val_inc_pulse);
            2'd1:    mm_d = ms_step(mm_q, i_val_inc_pulse);
            2'd2:    ss_d = ms_step(ss_q, i_val_inc_pulse);
            default: ;
          endcase
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered output values derived from the current state
  always_comb begin
    edit_d    = (state_q == S_EDIT);
    load_d    = (state_q == S_COMMIT);
    disp_hh_d = hh_q;
    disp_mm_d = mm_q;
    disp_ss_d = ss_q;
    set_hh_d  = set_hh_q;
    set_mm_d  = set_mm_q;
    set_ss_d  = set_ss_q;
    if (state_q == S_IDLE) begin
      disp_hh_d = i_cur_hh;
      disp_mm_d = i_cur_mm;
      disp_ss_d = i_cur_ss;
    end
    if (state_q == S_COMMIT) begin
      set_hh_d = hh_q;
      set_mm_d = mm_q;
      set_ss_d = ss_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      edit_q    <= 1'b0;
      load_q    <= 1'b0;
      disp_hh_q <= 5'd0;
      disp_mm_q <= 6'd0;
      disp_ss_q <= 6'd0;
      set_hh_q  <= 5'd0;
      set_mm_q  <= 6'd0;
      set_ss_q  <= 6'd0;
    end else begin
      edit_q    <= edit_d;
      load_q    <= load_d;
      disp_hh_q <= disp_hh_d;
      disp_mm_q <= disp_mm_d;
      disp_ss_q <= disp_ss_d;
      set_hh_q  <= set_hh_d;
      set_mm_q  <= set_mm_d;
      set_ss_q  <= set_ss_d;
    end
  end

`ifdef TIME_SET_BLINK_EN
  logic       blink_q, blink_d;
  logic [2:0] mask_q, mask_d;

  // Blink phase restarts visible on any edit activity; mask tracks the selected field
  always_comb begin
    blink_d = 1'b0;
    mask_d  = 3'b000;
    if (state_q == S_EDIT && state_d == S_EDIT) begin
      if (sel_any || val_any) blink_d = 1'b0;
      else if (i_tick)        blink_d = ~blink_q;
      else                    blink_d = blink_q;
    end
    if (blink_d) begin
      unique case (sel_d)
        2'd0:    mask_d = 3'b100;
        2'd1:    mask_d = 3'b010;
        2'd2:    mask_d = 3'b001;
        default: mask_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_q <= 1'b0;
      mask_q  <= 3'b000;
    end else begin
      blink_q <= blink_d;
      mask_q  <= mask_d;
    end
  end

  assign o_blink_mask = mask_q;
`else
  assign o_blink_mask = 3'b000;
`endif

  assign o_edit    = edit_q;
  assign o_sel     = sel_q;
  assign o_load    = load_q;
  assign o_disp_hh = disp_hh_q;
  assign o_disp_mm = disp_mm_q;
  assign o_disp_ss = disp_ss_q;
  assign o_set_hh  = set_hh_q;
  assign o_set_mm  = set_mm_q;
  assign o_set_ss  = set_ss_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl (TIMEOUT_S=3); checks editing, wrap, commit, timeout, reset and blink mask.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, wr = 1'b0, vi = 1'b0, vd = 1'b0, si = 1'b0, sd = 1'b0;
  logic [4:0] cur_hh = 5'd12;
  logic [5:0] cur_mm = 6'd34, cur_ss = 6'd56;
  logic       o_edit, o_load;
  logic [1:0] o_sel;
  logic [4:0] o_disp_hh, o_set_hh;
  logic [5:0] o_disp_mm, o_disp_ss, o_set_mm, o_set_ss;
  logic [2:0] o_blink_mask;

  int n_vec = 0;
  int n_err = 0;
  int load_seen = 0;
  int l0;

  time_set_ctrl #(.TIMEOUT_S(3), .HOUR_MAX(23)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_wr_pulse(wr),
    .i_val_inc_pulse(vi), .i_val_dec_pulse(vd),
    .i_sel_inc_pulse(si), .i_sel_dec_pulse(sd),
    .i_cur_hh(cur_hh), .i_cur_mm(cur_mm), .i_cur_ss(cur_ss),
    .o_edit(o_edit), .o_sel(o_sel),
    .o_disp_hh(o_disp_hh), .o_disp_mm(o_disp_mm), .o_disp_ss(o_disp_ss),
    .o_load(o_load), .o_set_hh(o_set_hh), .o_set_mm(o_set_mm), .o_set_ss(o_set_ss),
    .o_blink_mask(o_blink_mask)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_load === 1'b1) load_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulse set; returns two clock edges after the sampling edge
  task automatic drive(input logic t, input logic w, input logic i_vi, input logic i_vd,
                       input logic i_si, input logic i_sd);
    @(negedge clk);
    tick = t; wr = w; vi = i_vi; vd = i_vd; si = i_si; sd = i_sd;
    @(negedge clk);
    tick = 0; wr = 0; vi = 0; vd = 0; si = 0; sd = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    step(2);
    n_vec++; if ({o_edit, o_load, o_sel, o_disp_hh} !== 9'd0) begin n_err++;
      $display("FAIL in_reset got edit=%0d load=%0d sel=%0d hh=%0d exp all 0", o_edit, o_load, o_sel, o_disp_hh); end
    rst_n = 1'b1;
    step(2);
    n_vec++; if ({o_disp_hh, o_disp_mm, o_disp_ss} !== {5'd12, 6'd34, 6'd56}) begin n_err++;
      $display("FAIL idle_disp got %0d:%0d:%0d exp 12:34:56", o_disp_hh, o_disp_mm, o_disp_ss); end
    n_vec++; if ({o_edit, o_load, o_blink_mask} !== 5'd0) begin n_err++;
      $display("FAIL idle_flags got edit=%0d load=%0d mask=%0b exp 0 0 000", o_edit, o_load, o_blink_mask); end
    drive(0, 0, 1, 0, 1, 0);
    n_vec++; if ({o_edit, o_sel, o_disp_hh} !== {1'b0, 2'd0, 5'd12}) begin n_err++;
      $display("FAIL idle_ignore got edit=%0d sel=%0d hh=%0d exp 0 0 12", o_edit, o_sel, o_disp_hh); end
  endtask

  task automatic test_hour_wrap_commit;
    drive(0, 1, 0, 0, 0, 0);
    n_vec++; if ({o_edit, o_sel} !== {1'b1, 2'd0}) begin n_err++;
      $display("FAIL enter_edit got edit=%0d sel=%0d exp 1 0", o_edit, o_sel); end
    repeat (13) drive(0, 0, 0, 1, 0, 0);
    n_vec++; if ({o_disp_hh, o_disp_mm, o_disp_ss} !== {5'd23, 6'd34, 6'd56}) begin n_err++;
      $display("FAIL hh_dec_wrap got %0d:%0d:%0d exp 23:34:56", o_disp_hh, o_disp_mm, o_disp_ss); end
    l0 = load_seen;
    drive(0, 1, 0, 0, 0, 0);
    n_vec++; if ({o_load, o_edit, o_set_hh, o_set_mm, o_set_ss} !== {1'b1, 1'b0, 5'd23, 6'd34, 6'd56}) begin n_err++;
      $display("FAIL commit got load=%0d edit=%0d set=%0d:%0d:%0d exp 1 0 23:34:56",
               o_load, o_edit, o_set_hh, o_set_mm, o_set_ss); end
    step(3);
    n_vec++; if (load_seen - l0 !== 1) begin n_err++;
      $display("FAIL load_once got %0d load cycles exp 1", load_seen - l0); end
    n_vec++; if ({o_edit, o_set_hh, o_disp_hh} !== {1'b0, 5'd23, 5'd12}) begin n_err++;
      $display("FAIL after_commit got edit=%0d set_hh=%0d disp_hh=%0d exp 0 23 12", o_edit, o_set_hh, o_disp_hh); end
  endtask

  task automatic test_sel_ss_wrap;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    n_vec++; if (o_sel !== 2'd2) begin n_err++;
      $display("FAIL sel_dec_wrap got %0d exp 2", o_sel); end
    drive(0, 0, 1, 0, 0, 0);
    n_vec++; if (o_disp_ss !== 6'd57) begin n_err++;
      $display("FAIL ss_inc got %0d exp 57", o_disp_ss); end
    repeat (3) drive(0, 0, 1, 0, 0, 0);
    n_vec++; if ({o_disp_hh, o_disp_mm, o_disp_ss} !== {5'd12, 6'd34, 6'd0}) begin n_err++;
      $display("FAIL ss_wrap got %0d:%0d:%0d exp 12:34:0", o_disp_hh, o_disp_mm, o_disp_ss); end
    drive(0, 0, 0, 0, 1, 0);
    n_vec++; if (o_sel !== 2'd0) begin n_err++;
      $display("FAIL sel_inc_wrap got %0d exp 0", o_sel); end
  endtask

  task automatic test_simultaneous;
    drive(0, 0, 0, 0, 1, 1);
    n_vec++; if (o_sel !== 2'd0) begin n_err++;
      $display("FAIL sel_both got %0d exp 0", o_sel); end
    drive(0, 0, 1, 1, 0, 0);
    n_vec++; if ({o_disp_hh, o_disp_mm, o_disp_ss} !== {5'd12, 6'd34, 6'd0}) begin n_err++;
      $display("FAIL val_both got %0d:%0d:%0d exp 12:34:0", o_disp_hh, o_disp_mm, o_disp_ss); end
    l0 = load_seen;
    drive(0, 1, 1, 0, 0, 0);
    n_vec++; if ({o_load, o_set_hh, o_set_mm, o_set_ss} !== {1'b1, 5'd12, 6'd34, 6'd0}) begin n_err++;
      $display("FAIL wr_over_val got load=%0d set=%0d:%0d:%0d exp 1 12:34:0", o_load, o_set_hh, o_set_mm, o_set_ss); end
    step(2);
    n_vec++; if (load_seen - l0 !== 1) begin n_err++;
      $display("FAIL wr_val_load_once got %0d exp 1", load_seen - l0); end
  endtask

  task automatic test_timeout;
    l0 = load_seen;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    n_vec++; if (o_edit !== 1'b1) begin n_err++;
      $display("FAIL before_timeout got edit=%0d exp 1", o_edit); end
    drive(1, 0, 0, 0, 0, 0);
    n_vec++; if ({o_edit, o_sel, o_disp_hh} !== {1'b0, 2'd1, 5'd12}) begin n_err++;
      $display("FAIL timeout_abort got edit=%0d sel=%0d hh=%0d exp 0 1 12", o_edit, o_sel, o_disp_hh); end
    n_vec++; if (load_seen - l0 !== 0) begin n_err++;
      $display("FAIL timeout_noload got %0d exp 0", load_seen - l0); end
    drive(0, 1, 0, 0, 0, 0);
    n_vec++; if (o_sel !== 2'd0) begin n_err++;
      $display("FAIL sel_forced got %0d exp 0", o_sel); end
    drive(1, 0, 0, 0, 0, 0);
`ifdef TIME_SET_BLINK_EN
    n_vec++; if (o_blink_mask !== 3'b100) begin n_err++;
      $display("FAIL blink_on got %0b exp 100", o_blink_mask); end
`else
    n_vec++; if (o_blink_mask !== 3'b000) begin n_err++;
      $display("FAIL blink_off got %0b exp 000", o_blink_mask); end
`endif
    drive(1, 0, 0, 0, 0, 0);
    n_vec++; if (o_blink_mask !== 3'b000) begin n_err++;
      $display("FAIL blink_toggle got %0b exp 000", o_blink_mask); end
    drive(1, 0, 1, 0, 0, 0);
    n_vec++; if ({o_edit, o_disp_hh} !== {1'b1, 5'd13}) begin n_err++;
      $display("FAIL pulse_beats_timeout got edit=%0d hh=%0d exp 1 13", o_edit, o_disp_hh); end
    drive(1, 0, 0, 0, 0, 0);
    n_vec++; if (o_edit !== 1'b1) begin n_err++;
      $display("FAIL timeout_restarted got edit=%0d exp 1", o_edit); end
  endtask

  task automatic test_async_reset;
    l0 = load_seen;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({o_edit, o_sel, o_disp_hh, o_disp_mm, o_disp_ss, o_blink_mask} !== 23'd0) begin n_err++;
      $display("FAIL async_rst got edit=%0d sel=%0d disp=%0d:%0d:%0d mask=%0b exp all 0",
               o_edit, o_sel, o_disp_hh, o_disp_mm, o_disp_ss, o_blink_mask); end
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    n_vec++; if ({o_edit, o_disp_hh, o_set_hh, o_set_ss} !== {1'b0, 5'd12, 5'd0, 6'd0}) begin n_err++;
      $display("FAIL post_rst got edit=%0d disp_hh=%0d set_hh=%0d set_ss=%0d exp 0 12 0 0",
               o_edit, o_disp_hh, o_set_hh, o_set_ss); end
    n_vec++; if (load_seen - l0 !== 0) begin n_err++;
      $display("FAIL rst_noload got %0d exp 0", load_seen - l0); end
  endtask

  initial begin
    test_reset;
    test_hour_wrap_commit;
    test_sel_ss_wrap;
    test_simultaneous;
    test_timeout;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
